serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Serial frame transmitter. Accepts a parallel data word through a valid/ready handshake and sends it one bit per clock on a single serial line. Each frame starts with a fixed sync pattern (default `101`), followed by the payload MSB-first, an optional parity bit, and a run of idle zeros. It is the transmit end of the serial sync-pattern link: the sequence-detector FSM on the receive side fires on the sync pattern and frames the bits that follow.

## Interface
- `DATA_W`, default 8: payload width in bits, ≥1.
- `SYNC_W`, default 3: sync pattern width, ≥1.
- `SYNC_PAT`, default `3'b101`: sync pattern, sent MSB first.
- `GAP_LEN`, default 2: idle zero bits after each frame, ≥1.
- `i_clk`, in, 1: clock, rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_data`, in, `DATA_W`: payload, sampled on handshake.
- `i_valid`, in, 1: payload offered.
- `o_ready`, out, 1: transmitter can accept.
- `o_bit`, out, 1: serial line, registered.
- `o_bit_en`, out, 1: high while `o_bit` carries a sync, data or parity bit.
- `o_busy`, out, 1: high in every state except IDLE.

## Operation
- **States:** IDLE, SYNC, DATA, PARITY (only with the macro), GAP.
- **IDLE:** `o_ready`=1, `o_bit`=0, `o_bit_en`=0.
  - On `i_valid & o_ready`, latch `i_data` into a shift register, load the bit counter, and go to SYNC.
  - `o_ready` is low in all other states. `i_valid` is ignored outside IDLE.
- **SYNC:**
  - Emit `SYNC_PAT[SYNC_W-1]` down to `[0]`, one bit per cycle.
  - After `SYNC_W` bits, go to DATA.
- **DATA:**
  - Emit the latched word MSB first.
  - After `DATA_W` bits, go to PARITY if the macro is defined, otherwise to GAP.
- **PARITY:** emit one even-parity bit (XOR of the latched payload), then go to GAP.
- **GAP:**
  - Emit `GAP_LEN` zeros with `o_bit_en`=0, then return to IDLE.
  - The gap guarantees the receiver sees a clean return to its initial state between frames.
- **Payload is not bit-stuffed.** A sync-like pattern inside the payload is legal. The receiver qualifies bits by frame position.
- **Bit counter:** width `$clog2(max(SYNC_W, DATA_W, GAP_LEN)+1)`. It counts down and is reloaded on each state entry. It never wraps.
- **Illegal state encoding:** return to IDLE on the next clock.
- **Reset:**
  - Asserting `i_rst_n` low at any time, including mid-frame, forces state=IDLE, `o_bit`=0, `o_bit_en`=0, `o_busy`=0 and `o_ready`=1 immediately.
  - The shift register is cleared.
  - A partially sent frame is abandoned, never resumed.

## Timing
- Handshake at rising edge T (IDLE, `i_valid`=1). The first sync bit is on `o_bit` during cycle T+1.
- Sync bits occupy T+1..T+`SYNC_W`.
- Data bits occupy the next `DATA_W` cycles. Parity, if enabled, takes 1 cycle.
- The gap takes `GAP_LEN` cycles. IDLE with `o_ready`=1 follows immediately.
- Frame period with `i_valid` held high:
  - `1+SYNC_W+DATA_W+GAP_LEN` cycles (14 at defaults).
  - One more (15) with parity enabled.
- `o_ready` is a registered state decode. There is no combinational path from `i_valid` to `o_ready`.
- `o_bit`, `o_bit_en` and `o_busy` change only on `i_clk` edges, apart from asynchronous reset.

## Configuration
- **`SERIAL_FRAME_TX_PARITY_EN` defined:**
  - PARITY state exists.
  - One even-parity bit follows the payload with `o_bit_en`=1.
  - Frame period increases by 1.
- **Undefined:** PARITY is not compiled. DATA goes directly to GAP.

## Structure
- **Package `serial_frame_pkg`:**
  - State enum `tx_state_t`.
  - Default `SYNC_PAT`/`SYNC_W` localparams shared with the receiver.
  - Parity helper function.
- **Sub-module `serial_frame_shifter`:**
  - Loadable MSB-first shift register.
  - Down-counter with `load`/`shift`/`done` signals.
  - The FSM instantiates one.

## Test plan
- **Basic frame:** reset, then send `8'hA5` (defaults, no parity).
  - `o_bit` from T+1 = 1,0,1, 1,0,1,0,0,1,0,1, then 0,0.
  - `o_bit_en`=1 for exactly 11 cycles.
  - `o_ready`=1 at T+14.
- **Parity enabled:** send `8'hA5` → parity bit 0 at T+12. Send `8'h01` → parity 1. Period 15.
- **Back-to-back:** `i_valid` held with `8'hFF` then `8'h00`.
  - The second frame's first sync bit appears exactly 14 cycles after the first.
  - No bits are lost or duplicated.
- **Ignored input:** pulse `i_valid` with `8'h3C` during DATA of an `8'hC3` frame. Only `8'hC3` is transmitted.
- **Mid-frame reset:** assert `i_rst_n`=0 during the 5th data bit.
  - `o_bit`/`o_bit_en`/`o_busy` go to 0 and `o_ready` to 1 without a clock edge.
  - After release, a new `8'h5A` frame is sent correctly.
- **Loopback:** feed `o_bit` into the receive sequence detector. Its output pulses at each frame's third sync bit.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared types, defaults and helpers for the serial sync-pattern link
// Optional feature macro: SERIAL_FRAME_TX_PARITY_EN (adds the PARITY state)
package serial_frame_pkg;

  // Sync pattern defaults, shared with the receive-side sequence detector
  localparam int                      SYNC_W_DEF   = 3;
  localparam logic [SYNC_W_DEF-1:0]   SYNC_PAT_DEF = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_DATA   = 3'd2,
    ST_GAP    = 3'd3
`ifdef SERIAL_FRAME_TX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } tx_state_t;

  // Even parity: the bit that makes the total count of ones even
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// rtl/serial_frame_tx_if.sv - parallel handshake and serial line bundle of the frame transmitter
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic              o_bit;
  logic              o_bit_en;
  logic              o_busy;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready,
    input  o_bit,
    input  o_bit_en,
    input  o_busy
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready,
    output o_bit,
    output o_bit_en,
    output o_busy
  );
endinterface

// File: rtl/serial_frame_shifter.sv
// rtl/serial_frame_shifter.sv - MSB-first payload shift register plus per-state bit down-counter
module serial_frame_shifter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_shift,
  input  logic              i_cnt_load,
  input  logic [CNT_W-1:0]  i_cnt_val,
  input  logic              i_cnt_dec,
  output logic              o_msb,
  output logic              o_next_msb,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_done
);

  logic [DATA_W-1:0] shreg_q;
  logic [CNT_W-1:0]  cnt_q;

  // Payload register: loaded on handshake, shifted left once per data bit sent
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg_q <= '0;
    end else if (i_load) begin
      shreg_q <= i_data;
    end else if (i_shift) begin
      shreg_q <= shreg_q << 1;
    end
  end

  // Down-counter: reloaded on each state entry, holds at zero rather than wrapping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_cnt_load) begin
      cnt_q <= i_cnt_val;
    end else if (i_cnt_dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign o_msb  = shreg_q[DATA_W-1];
  assign o_cnt  = cnt_q;
  assign o_done = (cnt_q == '0);

  // Bit that becomes the MSB after the next shift; the FSM registers it one cycle early
  generate
    if (DATA_W > 1) begin : g_next_msb
      assign o_next_msb = shreg_q[DATA_W-2];
    end else begin : g_next_msb_w1
      assign o_next_msb = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - serial frame transmitter: sync pattern, MSB-first payload, optional parity, idle gap
// Optional feature macro: SERIAL_FRAME_TX_PARITY_EN (even-parity bit after the payload)
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
  parameter int                GAP_LEN  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  serial_frame_tx_if.slave   bus
);

  localparam int CNT_MAX = max3(SYNC_W, DATA_W, GAP_LEN);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  tx_state_t        state_q, state_d;
  logic             bit_q, bit_d;
  logic             en_q, en_d;
  logic             busy_q;
  logic             ready_q;

  logic             sh_load, sh_shift;
  logic             cnt_load, cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             sh_msb, sh_next_msb, cnt_done;
  logic [CNT_W-1:0] cnt_q;
  logic             sync_next;

  serial_frame_shifter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shifter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (sh_load),
    .i_data     (bus.i_data),
    .i_shift    (sh_shift),
    .i_cnt_load (cnt_load),
    .i_cnt_val  (cnt_val),
    .i_cnt_dec  (cnt_dec),
    .o_msb      (sh_msb),
    .o_next_msb (sh_next_msb),
    .o_cnt      (cnt_q),
    .o_done     (cnt_done)
  );

`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic par_q;

  // Parity is taken from the word as latched, since the shift register is consumed while sending
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      par_q <= 1'b0;
    end else if (sh_load) begin
      par_q <= even_parity(64'(bus.i_data));
    end
  end
`endif

  // Next state plus the next serial bit; outputs are registered so bits are computed one cycle ahead
  always_comb begin
    state_d   = state_q;
    bit_d     = 1'b0;
    en_d      = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    sync_next = 1'b0;
    // In SYNC the counter holds the index of the bit on the line; the next one is index-1
    for (int i = 0; i < SYNC_W; i++) begin
      if (cnt_q == CNT_W'(i + 1)) sync_next = SYNC_PAT[i];
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          state_d  = ST_SYNC;
          sh_load  = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(SYNC_W - 1);
          bit_d    = SYNC_PAT[SYNC_W-1];
          en_d     = 1'b1;
        end
      end
      ST_SYNC: begin
        en_d = 1'b1;
        if (cnt_done) begin
          state_d  = ST_DATA;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(DATA_W - 1);
          bit_d    = sh_msb;
        end else begin
          cnt_dec = 1'b1;
          bit_d   = sync_next;
        end
      end
      ST_DATA: begin
        if (cnt_done) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          state_d  = ST_PARITY;
          cnt_load = 1'b1;
          cnt_val  = '0;
          bit_d    = par_q;
          en_d     = 1'b1;
`else
          state_d  = ST_GAP;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(GAP_LEN - 1);
`endif
        end else begin
          sh_shift = 1'b1;
          cnt_dec  = 1'b1;
          bit_d    = sh_next_msb;
          en_d     = 1'b1;
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      ST_PARITY: begin
        state_d  = ST_GAP;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(GAP_LEN - 1);
      end
`endif
      ST_GAP: begin
        if (cnt_done) begin
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered line outputs; ready/busy are decodes of the state being entered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      bit_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      en_q    <= en_d;
      busy_q  <= (state_d != ST_IDLE);
      ready_q <= (state_d == ST_IDLE);
    end
  end

  assign bus.o_bit    = bit_q;
  assign bus.o_bit_en = en_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_ready  = ready_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - self-checking bench for serial_frame_tx (honours SERIAL_FRAME_TX_PARITY_EN)
module tb_serial_frame_tx;

  localparam int DW = 8;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int EN_LEN = 3 + DW + PB;
  localparam int FL     = EN_LEN + 2;
  localparam int PERIOD = FL + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [15:0]   pat;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_frame_tx_if #(.DATA_W(DW)) bus();

  serial_frame_tx #(
    .DATA_W   (DW),
    .SYNC_W   (3),
    .SYNC_PAT (3'b101),
    .GAP_LEN  (2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0] mq[$];
  logic       m_ready = 1'b1;
  vec_t       vecs[6];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame as a list of {bit_en, bit} line cycles
  task automatic push_frame(input logic [DW-1:0] d);
    logic [2:0] sp;
    sp = 3'b101;
    for (int i = 2; i >= 0; i--) mq.push_back({1'b1, sp[i]});
    for (int i = DW - 1; i >= 0; i--) mq.push_back({1'b1, d[i]});
`ifdef SERIAL_FRAME_TX_PARITY_EN
    mq.push_back({1'b1, ^d});
`endif
    mq.push_back(2'b00);
    mq.push_back(2'b00);
  endtask

  task automatic step();
    logic [1:0] e;
    logic       e_busy;
    logic       e_ready;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_ready = 1'b1;
    end else if (m_ready && bus.i_valid) begin
      push_frame(bus.i_data);
    end
    if (rst_n && mq.size() > 0) begin
      e       = mq.pop_front();
      e_busy  = 1'b1;
      e_ready = 1'b0;
      m_ready = 1'b0;
    end else begin
      e       = 2'b00;
      e_busy  = 1'b0;
      e_ready = 1'b1;
      m_ready = 1'b1;
    end
    @(negedge clk);
    check_val("model_bit",    32'(bus.o_bit),    32'(e[0]));
    check_val("model_bit_en", 32'(bus.o_bit_en), 32'(e[1]));
    check_val("model_busy",   32'(bus.o_busy),   32'(e_busy));
    check_val("model_ready",  32'(bus.o_ready),  32'(e_ready));
  endtask

  task automatic run_vector(input logic [DW-1:0] d, input logic [15:0] pat);
    logic [15:0] got;
    int          en_cnt;
    got         = '0;
    en_cnt      = 0;
    bus.i_data  = d;
    bus.i_valid = 1'b1;
    for (int k = 0; k < FL; k++) begin
      step();
      if (k == 0) bus.i_valid = 1'b0;
      got    = {got[14:0], bus.o_bit};
      en_cnt = en_cnt + int'(bus.o_bit_en);
    end
    check_val("frame_bits", 32'(got), 32'(pat));
    check_val("en_cycles", 32'(en_cnt), 32'(EN_LEN));
    step();
    check_val("ready_after_frame", 32'(bus.o_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          rises[$];
    logic        prev_en;
    logic [15:0] got;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    vecs[0] = '{8'hA5, 16'b10110100101000};
    vecs[1] = '{8'h01, 16'b10100000001100};
    vecs[2] = '{8'hFF, 16'b10111111111000};
    vecs[3] = '{8'h00, 16'b10100000000000};
    vecs[4] = '{8'h80, 16'b10110000000100};
    vecs[5] = '{8'h5A, 16'b10101011010000};
`else
    vecs[0] = '{8'hA5, 16'b1011010010100};
    vecs[1] = '{8'h01, 16'b1010000000100};
    vecs[2] = '{8'hFF, 16'b1011111111100};
    vecs[3] = '{8'h00, 16'b1010000000000};
    vecs[4] = '{8'h80, 16'b1011000000000};
    vecs[5] = '{8'h5A, 16'b1010101101000};
`endif

    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    rst_n       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Table-driven single frames
    for (int v = 0; v < 6; v++) begin
      run_vector(vecs[v].data, vecs[v].pat);
    end

    // Back-to-back with valid held: second frame starts one period after the first
    bus.i_data  = 8'hFF;
    bus.i_valid = 1'b1;
    prev_en     = 1'b0;
    for (int k = 0; k < 2 * PERIOD; k++) begin
      step();
      if (k == 0) bus.i_data = 8'h00;
      if (k == PERIOD) bus.i_valid = 1'b0;
      if (bus.o_bit_en && !prev_en) rises.push_back(k);
      prev_en = bus.o_bit_en;
    end
    check_val("b2b_frame_count", 32'(rises.size()), 32'd2);
    if (rises.size() >= 2) check_val("b2b_period", 32'(rises[1] - rises[0]), 32'(PERIOD));

    // Valid pulsed mid-frame must be ignored
    got         = '0;
    bus.i_data  = 8'hC3;
    bus.i_valid = 1'b1;
    for (int k = 0; k < FL; k++) begin
      step();
      if (k == 0) bus.i_valid = 1'b0;
      if (k == 5) begin
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h3C;
      end
      if (k == 6) bus.i_valid = 1'b0;
      got = {got[14:0], bus.o_bit};
    end
`ifdef SERIAL_FRAME_TX_PARITY_EN
    check_val("ignored_input_bits", 32'(got), 32'(16'b10111000011000));
`else
    check_val("ignored_input_bits", 32'(got), 32'(16'b1011100001100));
`endif
    for (int k = 0; k < 3; k++) step();
    check_val("ignored_input_idle", 32'(bus.o_busy), 32'd0);

    // Asynchronous reset during the 5th data bit
    bus.i_data  = 8'hA5;
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    for (int k = 0; k < 7; k++) step();
    check_val("pre_reset_bit_en", 32'(bus.o_bit_en), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_bit",    32'(bus.o_bit),    32'd0);
    check_val("async_rst_bit_en", 32'(bus.o_bit_en), 32'd0);
    check_val("async_rst_busy",   32'(bus.o_busy),   32'd0);
    check_val("async_rst_ready",  32'(bus.o_ready),  32'd1);
    step();
    rst_n = 1'b1;
    step();
    run_vector(vecs[5].data, vecs[5].pat);

    // Randomized traffic against the frame-list model
    for (int k = 0; k < 400; k++) begin
      bus.i_valid = ($urandom_range(0, 3) != 0);
      bus.i_data  = DW'($urandom);
      step();
    end
    bus.i_valid = 1'b0;
    for (int k = 0; k < PERIOD + 2; k++) step();
    check_val("final_idle_ready", 32'(bus.o_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
